// File: rtl/reg_group_seq_pkg.sv
// Shared constants for the register-group micro-sequencer: widths, opcodes, states.
// Latency: n/a (package).
// Backpressure: n/a (package).
package reg_group_seq_pkg;

  localparam int DW_DEF   = 8;
  localparam int NREG_DEF = 3;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_MOV  = 4'h1;
  localparam logic [3:0] OP_ADD  = 4'h2;
  localparam logic [3:0] OP_SUB  = 4'h3;
  localparam logic [3:0] OP_AND  = 4'h4;
  localparam logic [3:0] OP_OR   = 4'h5;
  localparam logic [3:0] OP_XOR  = 4'h6;
  localparam logic [3:0] OP_NOT  = 4'h7;
  localparam logic [3:0] OP_LDI  = 4'h8;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_READ,
    ST_EXEC,
    ST_WB,
    ST_IMM,
    ST_HALT
  } state_t;

  // Opcodes that read ra/rb through the register group and go via the ALU.
  function automatic logic op_is_alu(input logic [3:0] op);
    return (op >= OP_MOV) && (op <= OP_NOT);
  endfunction

endpackage

// File: rtl/reg_group_seq_if.sv
// Instruction-fetch handshake plus register-group read/write ports.
// Latency: n/a (wiring only).
// Backpressure: instr_req from the sequencer gates acceptance of instr_vld.
interface reg_group_seq_if
  import reg_group_seq_pkg::*;
#(
  parameter int DW = DW_DEF
);
  logic          instr_req;
  logic          instr_vld;
  logic [DW-1:0] instr;
  logic [1:0]    raa;
  logic [1:0]    rwba;
  logic          we;
  logic [DW-1:0] wdata;
  logic [DW-1:0] s;
  logic [DW-1:0] d;

  modport master (
    output instr_req, raa, rwba, we, wdata,
    input  instr_vld, instr, s, d
  );

  modport slave (
    input  instr_req, raa, rwba, we, wdata,
    output instr_vld, instr, s, d
  );
endinterface

// File: rtl/reg_group_seq_alu.sv
// Combinational ALU: result = op(b, a) with carry/borrow and zero flags.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
module reg_group_seq_alu
  import reg_group_seq_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic [3:0]    op,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [DW-1:0] result,
  output logic          cf,
  output logic          zf
);

  logic [DW:0] sum;
  logic [DW:0] diff;

  // a is the source (ra) operand, b the destination (rb) operand; SUB is b - a.
  always_comb begin
    sum    = {1'b0, b} + {1'b0, a};
    diff   = {1'b0, b} - {1'b0, a};
    result = '0;
    cf     = 1'b0;
    case (op)
      OP_MOV:  result = a;
      OP_ADD:  {cf, result} = sum;
      OP_SUB:  {cf, result} = diff;
      OP_AND:  result = b & a;
      OP_OR:   result = b | a;
      OP_XOR:  result = b ^ a;
      OP_NOT:  result = ~a;
      default: result = '0;
    endcase
    zf = (result == '0);
  end

endmodule

// File: rtl/reg_group_seq.sv
// Micro-sequencer: fetch byte, decode, read A/B/C via s/d, ALU, write back with active-low we.
// Latency: ALU/MOV accept -> WB in 3 cycles (READ, EXEC, WB); LDI immediate accept -> WB next cycle.
// Backpressure: instr_req high only in FETCH/IMM; stalls indefinitely while instr_vld is low.
module reg_group_seq
  import reg_group_seq_pkg::*;
#(
  parameter int DW   = DW_DEF,
  parameter int NREG = NREG_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  reg_group_seq_if.master        bus,
  output logic                   busy,
  output logic                   halted,
  output logic                   illegal,
  output logic                   zf,
  output logic                   cf,
  output logic [7:0]             pc
);

  state_t        state, state_nx;
  logic          instr_req_w;
  logic          accept;
  logic          ill_nx;
  logic [3:0]    op_in;
  logic [1:0]    ra_in;
  logic [1:0]    rb_in;
  logic [3:0]    op_q;
  logic [DW-1:0] a_q, b_q;
  logic [1:0]    raa_q, rwba_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] alu_res;
  logic          alu_cf, alu_zf;

  function automatic logic reg_ok(input logic [1:0] r);
    return int'(r) < NREG;
  endfunction

  assign op_in       = bus.instr[7:4];
  assign ra_in       = bus.instr[3:2];
  assign rb_in       = bus.instr[1:0];
  assign instr_req_w = (state == ST_FETCH) || (state == ST_IMM);
  assign accept      = instr_req_w && bus.instr_vld;

  assign bus.instr_req = instr_req_w;
  assign bus.raa       = raa_q;
  assign bus.rwba      = rwba_q;
  assign bus.wdata     = wdata_q;
  // rst masks the write strobe too, so a reset landing inside WB can never commit a write.
  assign bus.we        = !(state == ST_WB) || rst;
  assign busy          = (state != ST_IDLE) && (state != ST_HALT);
  assign halted        = (state == ST_HALT);

  reg_group_seq_alu #(.DW(DW)) u_alu (
    .op     (op_q),
    .a      (a_q),
    .b      (b_q),
    .result (alu_res),
    .cf     (alu_cf),
    .zf     (alu_zf)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  // Next-state decode; bad opcodes and bad register indices fall back to FETCH as a NOP.
  always_comb begin
    state_nx = state;
    ill_nx   = 1'b0;
    case (state)
      ST_IDLE:  if (start) state_nx = ST_FETCH;
      ST_FETCH: begin
        if (accept) begin
          if (op_in == OP_HALT) begin
            state_nx = ST_HALT;
          end else if (op_in == OP_NOP) begin
            state_nx = ST_FETCH;
          end else if (op_is_alu(op_in)) begin
            if (reg_ok(ra_in) && reg_ok(rb_in)) state_nx = ST_READ;
            else                                ill_nx   = 1'b1;
          end else if (op_in == OP_LDI) begin
            if (reg_ok(rb_in)) state_nx = ST_IMM;
            else               ill_nx   = 1'b1;
          end else begin
            ill_nx = 1'b1;
          end
        end
      end
      ST_READ:  state_nx = ST_EXEC;
      ST_EXEC:  state_nx = ST_WB;
      ST_WB:    state_nx = ST_FETCH;
      ST_IMM:   if (accept) state_nx = ST_WB;
      ST_HALT:  if (start) state_nx = ST_FETCH;
      default:  state_nx = ST_IDLE;
    endcase
  end

  // Datapath: register selects, operand capture, result/flag registers, pc and illegal pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      raa_q   <= '0;
      rwba_q  <= '0;
      wdata_q <= '0;
      op_q    <= OP_NOP;
      a_q     <= '0;
      b_q     <= '0;
      zf      <= 1'b0;
      cf      <= 1'b0;
      pc      <= '0;
      illegal <= 1'b0;
    end else begin
      illegal <= ill_nx;
      if (accept) pc <= pc + 8'd1;
      if (state == ST_FETCH && state_nx == ST_READ) begin
        raa_q  <= ra_in;
        rwba_q <= rb_in;
        op_q   <= op_in;
      end
      if (state == ST_FETCH && state_nx == ST_IMM) rwba_q <= rb_in;
      if (state == ST_IMM && accept) wdata_q <= bus.instr;
      if (state == ST_READ) begin
        a_q <= bus.s;
        b_q <= bus.d;
      end
      if (state == ST_EXEC) begin
        wdata_q <= alu_res;
        if (op_q != OP_MOV) begin
          zf <= alu_zf;
          cf <= alu_cf;
        end
      end
    end
  end

endmodule

// File: tb/tb_reg_group_seq.sv
// Bench for reg_group_seq: register-group model on the bus plus an instruction-level reference.
// Latency: n/a.
// Backpressure: random instr_vld gaps exercise FETCH/IMM stalls.
module tb_reg_group_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       busy, halted, illegal, zf, cf;
  logic [7:0] pc;

  reg_group_seq_if #(.DW(8)) bus ();

  reg_group_seq dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .bus     (bus),
    .busy    (busy),
    .halted  (halted),
    .illegal (illegal),
    .zf      (zf),
    .cf      (cf),
    .pc      (pc)
  );

  always #5 clk = ~clk;

  // Register group A/B/C: combinational reads, negedge write when we is low.
  logic [7:0] rf [3] = '{8'h11, 8'h22, 8'h33};
  assign bus.s = (bus.raa  < 2'd3) ? rf[bus.raa]  : 8'h00;
  assign bus.d = (bus.rwba < 2'd3) ? rf[bus.rwba] : 8'h00;

  int checks = 0, errors = 0;
  int wr_cnt = 0, ill_cnt = 0, we_run = 0, we_run_max = 0, bad_we = 0;

  // Reference machine state, instruction level.
  logic [7:0] m_rf [3] = '{8'h11, 8'h22, 8'h33};
  logic       m_zf = 1'b0, m_cf = 1'b0, m_halt = 1'b0;
  logic [7:0] m_pc = 8'h00;
  int         m_wr = 0, m_ill = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Register-group side: perform writes, count strobes and illegal pulses.
  always @(negedge clk) begin
    if (illegal === 1'b1) ill_cnt++;
    if (bus.we === 1'b0) begin
      wr_cnt++;
      we_run++;
      if (we_run > we_run_max) we_run_max = we_run;
      if (busy !== 1'b1) bad_we++;
      if (bus.rwba < 2'd3) rf[bus.rwba] = bus.wdata;
      else bad_we++;
    end else begin
      we_run = 0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic model_exec(input logic [7:0] b0, input logic [7:0] b1);
    logic [3:0] op;
    int ra, rb, x, y, r;
    op = b0[7:4];
    ra = int'(b0[3:2]);
    rb = int'(b0[1:0]);
    m_pc = m_pc + 8'd1;
    if (op == 4'h0) begin
      // NOP
    end else if (op >= 4'h1 && op <= 4'h7) begin
      if (ra > 2 || rb > 2) begin
        m_ill++;
      end else begin
        x = int'(m_rf[ra]);
        y = int'(m_rf[rb]);
        case (op)
          4'h1:    r = x;
          4'h2:    r = y + x;
          4'h3:    r = y - x;
          4'h4:    r = y & x;
          4'h5:    r = y | x;
          4'h6:    r = y ^ x;
          default: r = ~x;
        endcase
        if (op != 4'h1) begin
          m_zf = (r[7:0] == 8'h00);
          m_cf = (op == 4'h2) ? (r > 255) : (op == 4'h3) ? (y < x) : 1'b0;
        end
        m_rf[rb] = r[7:0];
        m_wr++;
      end
    end else if (op == 4'h8) begin
      if (rb > 2) begin
        m_ill++;
      end else begin
        m_rf[rb] = b1;
        m_wr++;
        m_pc = m_pc + 8'd1;
      end
    end else if (op == 4'hF) begin
      m_halt = 1'b1;
    end else begin
      m_ill++;
    end
  endtask

  task automatic compare_all(input string tag);
    for (int i = 0; i < 3; i++) chk($sformatf("%s rf%0d", tag, i), rf[i], m_rf[i]);
    chk({tag, " zf"}, zf, m_zf);
    chk({tag, " cf"}, cf, m_cf);
    chk({tag, " pc"}, pc, m_pc);
    chk({tag, " illegal_cnt"}, ill_cnt, m_ill);
    chk({tag, " write_cnt"}, wr_cnt, m_wr);
    chk({tag, " halted"}, halted, m_halt);
  endtask

  // Offer one byte after an optional idle gap; returns #1 after the accepting edge.
  task automatic send_byte(input logic [7:0] b, input int gap);
    logic [7:0] pc0;
    int n;
    pc0 = pc;
    bus.instr_vld = 1'b0;
    if (gap > 0) begin
      repeat (gap) @(posedge clk);
      #1;
      chk("stall pc", pc, pc0);
    end
    bus.instr     = b;
    bus.instr_vld = 1'b1;
    n = 0;
    while (bus.instr_req !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (bus.instr_req !== 1'b1) chk("accept timeout", 0, 1);
    @(posedge clk);
    #1;
    bus.instr_vld = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (bus.instr_req !== 1'b1 && halted !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (bus.instr_req !== 1'b1 && halted !== 1'b1) chk("idle timeout", 0, 1);
    #1;
  endtask

  task automatic do_instr(input logic [7:0] b0, input logic [7:0] b1, input string tag);
    send_byte(b0, $urandom_range(0, 2));
    if (b0[7:4] == 4'h8 && b0[1:0] != 2'd3) send_byte(b1, $urandom_range(0, 2));
    wait_idle();
    model_exec(b0, b1);
    compare_all(tag);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  initial begin
    logic [3:0] opr;
    logic [1:0] ra, rb;
    logic [7:0] b0;
    bus.instr_vld = 1'b0;
    bus.instr     = 8'h00;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst instr_req", bus.instr_req, 1'b0);
    chk("rst we", bus.we, 1'b1);
    chk("rst raa", bus.raa, 2'd0);
    chk("rst rwba", bus.rwba, 2'd0);
    chk("rst wdata", bus.wdata, 8'h00);
    chk("rst busy", busy, 1'b0);
    chk("rst halted", halted, 1'b0);
    chk("rst illegal", illegal, 1'b0);
    chk("rst zf", zf, 1'b0);
    chk("rst cf", cf, 1'b0);
    chk("rst pc", pc, 8'h00);
    rst = 1'b0;
    @(negedge clk);
    chk("idle no req", bus.instr_req, 1'b0);
    pulse_start();
    @(negedge clk);
    chk("start req", bus.instr_req, 1'b1);
    chk("start busy", busy, 1'b1);

    // A=5, B=3, B+=A
    do_instr(8'h80, 8'h05, "ldi_a");
    do_instr(8'h81, 8'h03, "ldi_b");
    do_instr(8'h21, 8'h00, "add_b");
    chk("add_b result", rf[1], 8'h08);
    chk("add_b pc", pc, 8'd5);

    // A=FF, B=01, A+=B wraps to zero with carry
    do_instr(8'h80, 8'hFF, "ldi_a2");
    do_instr(8'h81, 8'h01, "ldi_b2");
    do_instr(8'h24, 8'h00, "add_a_carry");
    chk("add carry zf", zf, 1'b1);
    chk("add carry cf", cf, 1'b1);
    chk("we pulse width", we_run_max, 1);

    // A=02, B=05, A-=B (encoding 0x34) borrows
    do_instr(8'h80, 8'h02, "ldi_a3");
    do_instr(8'h81, 8'h05, "ldi_b3");
    do_instr(8'h34, 8'h00, "sub_a_borrow");
    chk("sub result", rf[0], 8'hFD);
    chk("sub cf", cf, 1'b1);

    // Undefined opcode, then MOV with rb=3
    do_instr(8'h9C, 8'h00, "undef_op");
    do_instr(8'h13, 8'h00, "bad_reg");

    // Randomised instruction stream
    for (int k = 0; k < 80; k++) begin
      opr = 4'($urandom_range(0, 14));
      ra  = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      rb  = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      if (opr == 4'h0) b0 = 8'h00;
      else if (opr == 4'h8) b0 = {4'h8, 2'd0, 2'($urandom_range(0, 2))};
      else b0 = {opr, ra, rb};
      do_instr(b0, 8'($urandom), $sformatf("rnd%0d op%0h", k, b0));
    end

    // HALT, bytes offered while halted are ignored, start resumes
    do_instr(8'hF0, 8'h00, "halt");
    chk("halt req", bus.instr_req, 1'b0);
    chk("halt busy", busy, 1'b0);
    bus.instr = 8'h80;
    bus.instr_vld = 1'b1;
    repeat (3) @(negedge clk);
    chk("halt pc frozen", pc, m_pc);
    bus.instr_vld = 1'b0;
    pulse_start();
    m_halt = 1'b0;
    @(negedge clk);
    chk("resume req", bus.instr_req, 1'b1);
    chk("resume halted", halted, 1'b0);
    do_instr(8'h82, 8'h77, "ldi_c");

    // Reset raised in EXEC so the would-be WB edge sees it: no write to C
    send_byte(8'h12, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    m_pc = 8'h00;
    m_zf = 1'b0;
    m_cf = 1'b0;
    chk("rst_wb write_cnt", wr_cnt, m_wr);
    chk("rst_wb C kept", rf[2], 8'h77);
    chk("rst_wb busy", busy, 1'b0);
    chk("rst_wb req", bus.instr_req, 1'b0);
    chk("rst_wb pc", pc, 8'h00);
    rst = 1'b0;
    pulse_start();
    do_instr(8'h16, 8'h00, "mov_after_rst");

    chk("final we pulse width", we_run_max, 1);
    chk("we outside busy", bad_we, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
